// File: rtl/cpu_exec_core.sv
`timescale 1ns/1ps
// cpu_exec_core: multi-cycle regfile + 74181-style ALU execution core with C/Z/N flags.
// Ports:
//   clk, reset (async active-low)
//   op_valid/op_ready handshake with op_dst, op_src_a, op_src_b, op_b_imm, op_imm,
//     op_mode, op_sel, op_cin, op_use_carry, op_wb operation fields
//   ext_we/ext_waddr/ext_wdata host register load (honoured only in IDLE)
//   dbg_raddr/dbg_rdata combinational register read
//   res_valid (one-cycle pulse), res_data, flag_c/flag_z/flag_n, busy
module cpu_exec_core #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [ADDR_WIDTH-1:0] op_dst,
    input  logic [ADDR_WIDTH-1:0] op_src_a,
    input  logic [ADDR_WIDTH-1:0] op_src_b,
    input  logic                  op_b_imm,
    input  logic [DATA_WIDTH-1:0] op_imm,
    input  logic                  op_mode,
    input  logic [3:0]            op_sel,
    input  logic                  op_cin,
    input  logic                  op_use_carry,
    input  logic                  op_wb,
    input  logic                  ext_we,
    input  logic [ADDR_WIDTH-1:0] ext_waddr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    input  logic [ADDR_WIDTH-1:0] dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  flag_c,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  busy
);
    localparam int NIB = DATA_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [ADDR_WIDTH-1:0] q_dst, q_src_a, q_src_b;
    logic                  q_b_imm, q_mode, q_cin, q_use_carry, q_wb;
    logic [DATA_WIDTH-1:0] q_imm;
    logic [3:0]            q_sel;
    logic [DATA_WIDTH-1:0] a, b;
    logic                  ci;
    logic [DATA_WIDTH-1:0] x, y, sum, alu_f;
    logic                  carry, alu_c;
    logic                  accept;

    assign op_ready  = (state == IDLE) || (state == WB);
    assign busy      = state != IDLE;
    assign accept    = op_valid && op_ready;
    assign dbg_rdata = regs[dbg_raddr];

    // 74181 decomposed into two bitwise terms: arithmetic is x + y + cin,
    // logic mode is the carry-free form ~(x ^ y).
    assign x = a | (b & {DATA_WIDTH{q_sel[0]}}) | (~b & {DATA_WIDTH{q_sel[1]}});
    assign y = (a & b & {DATA_WIDTH{q_sel[3]}}) | (a & ~b & {DATA_WIDTH{q_sel[2]}});

    // Carry ripples nibble to nibble, one slice per 4 bits.
    always_comb begin
        carry = ci;
        sum   = '0;
        for (int i = 0; i < NIB; i++) begin
            {carry, sum[4*i +: 4]} = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'b0, carry};
        end
    end

    assign alu_f = q_mode ? ~(x ^ y) : sum;
    assign alu_c = q_mode ? 1'b0 : carry;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            q_dst       <= '0;
            q_src_a     <= '0;
            q_src_b     <= '0;
            q_b_imm     <= 1'b0;
            q_imm       <= '0;
            q_mode      <= 1'b0;
            q_sel       <= '0;
            q_cin       <= 1'b0;
            q_use_carry <= 1'b0;
            q_wb        <= 1'b0;
            a           <= '0;
            b           <= '0;
            ci          <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
            flag_n      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (accept) begin
                q_dst       <= op_dst;
                q_src_a     <= op_src_a;
                q_src_b     <= op_src_b;
                q_b_imm     <= op_b_imm;
                q_imm       <= op_imm;
                q_mode      <= op_mode;
                q_sel       <= op_sel;
                q_cin       <= op_cin;
                q_use_carry <= op_use_carry;
                q_wb        <= op_wb;
            end
            // Host and write-back share one write port; they never overlap by state.
            if (state == IDLE && ext_we) regs[ext_waddr] <= ext_wdata;
            if (state == WB && q_wb) regs[q_dst] <= res_data;
            case (state)
                IDLE: state <= accept ? READ : IDLE;
                READ: begin
                    a     <= regs[q_src_a];
                    b     <= q_b_imm ? q_imm : regs[q_src_b];
                    ci    <= q_use_carry ? flag_c : q_cin;
                    state <= EXEC;
                end
                EXEC: begin
                    res_data  <= alu_f;
                    flag_c    <= alu_c;
                    flag_z    <= alu_f == '0;
                    flag_n    <= alu_f[DATA_WIDTH-1];
                    res_valid <= 1'b1;
                    state     <= WB;
                end
                default: state <= accept ? READ : IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_exec_core.sv
`timescale 1ns/1ps
// tb_cpu_exec_core: directed self-checking bench for cpu_exec_core (16-bit and 32-bit instances).
module tb_cpu_exec_core;
    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0, op_ready;
    logic [AW-1:0] op_dst = '0, op_src_a = '0, op_src_b = '0;
    logic          op_b_imm = 1'b0, op_mode = 1'b0, op_cin = 1'b0, op_use_carry = 1'b0, op_wb = 1'b0;
    logic [W-1:0]  op_imm = '0;
    logic [3:0]    op_sel = '0;
    logic          ext_we = 1'b0;
    logic [AW-1:0] ext_waddr = '0, dbg_raddr = '0;
    logic [W-1:0]  ext_wdata = '0, dbg_rdata, res_data;
    logic          res_valid, flag_c, flag_z, flag_n, busy;

    logic          w_op_valid = 1'b0, w_op_ready;
    logic [AW-1:0] w_op_dst = '0, w_op_src_a = '0, w_op_src_b = '0;
    logic          w_op_b_imm = 1'b0, w_op_mode = 1'b0, w_op_cin = 1'b0, w_op_use_carry = 1'b0, w_op_wb = 1'b0;
    logic [31:0]   w_op_imm = '0;
    logic [3:0]    w_op_sel = '0;
    logic          w_ext_we = 1'b0;
    logic [AW-1:0] w_ext_waddr = '0, w_dbg_raddr = '0;
    logic [31:0]   w_ext_wdata = '0, w_dbg_rdata, w_res_data;
    logic          w_res_valid, w_flag_c, w_flag_z, w_flag_n, w_busy;

    int total = 0;
    int bad   = 0;

    cpu_exec_core #(.DATA_WIDTH(W), .NUM_REGS(8)) u_dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op_dst(op_dst), .op_src_a(op_src_a), .op_src_b(op_src_b), .op_b_imm(op_b_imm),
        .op_imm(op_imm), .op_mode(op_mode), .op_sel(op_sel), .op_cin(op_cin),
        .op_use_carry(op_use_carry), .op_wb(op_wb), .ext_we(ext_we), .ext_waddr(ext_waddr),
        .ext_wdata(ext_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .res_valid(res_valid), .res_data(res_data), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .busy(busy)
    );

    cpu_exec_core #(.DATA_WIDTH(32), .NUM_REGS(8)) u_dut32 (
        .clk(clk), .reset(reset), .op_valid(w_op_valid), .op_ready(w_op_ready),
        .op_dst(w_op_dst), .op_src_a(w_op_src_a), .op_src_b(w_op_src_b), .op_b_imm(w_op_b_imm),
        .op_imm(w_op_imm), .op_mode(w_op_mode), .op_sel(w_op_sel), .op_cin(w_op_cin),
        .op_use_carry(w_op_use_carry), .op_wb(w_op_wb), .ext_we(w_ext_we), .ext_waddr(w_ext_waddr),
        .ext_wdata(w_ext_wdata), .dbg_raddr(w_dbg_raddr), .dbg_rdata(w_dbg_rdata),
        .res_valid(w_res_valid), .res_data(w_res_data), .flag_c(w_flag_c), .flag_z(w_flag_z),
        .flag_n(w_flag_n), .busy(w_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dbg_chk(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
        dbg_raddr = addr;
        #1;
        chk(tag, 32'(dbg_rdata), 32'(exp));
    endtask

    task automatic ext_wr(input logic [AW-1:0] addr, input logic [W-1:0] data);
        ext_we    = 1'b1;
        ext_waddr = addr;
        ext_wdata = data;
        @(negedge clk);
        ext_we = 1'b0;
    endtask

    task automatic drive_op(input logic [AW-1:0] dst, input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                            input logic bimm, input logic [W-1:0] imm, input logic mode,
                            input logic [3:0] sel, input logic cin, input logic usec, input logic wb);
        op_dst = dst; op_src_a = sa; op_src_b = sb; op_b_imm = bimm; op_imm = imm;
        op_mode = mode; op_sel = sel; op_cin = cin; op_use_carry = usec; op_wb = wb;
        op_valid = 1'b1;
    endtask

    // Issues an op from IDLE at a falling edge and checks the full 3-cycle latency.
    task automatic run_op(input string tag, input logic [AW-1:0] dst, input logic [AW-1:0] sa,
                          input logic [AW-1:0] sb, input logic bimm, input logic [W-1:0] imm,
                          input logic mode, input logic [3:0] sel, input logic cin, input logic usec,
                          input logic wb, input logic [W-1:0] er, input logic ec, input logic ez,
                          input logic en);
        drive_op(dst, sa, sb, bimm, imm, mode, sel, cin, usec, wb);
        @(negedge clk);
        op_valid = 1'b0;
        ext_we   = 1'b0;
        chk({tag, "_ready_read"}, 32'(op_ready), 32'd0);
        chk({tag, "_busy_read"}, 32'(busy), 32'd1);
        @(negedge clk);
        chk({tag, "_rv_exec"}, 32'(res_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_rv_wb"}, 32'(res_valid), 32'd1);
        chk({tag, "_res"}, 32'(res_data), 32'(er));
        chk({tag, "_c"}, 32'(flag_c), 32'(ec));
        chk({tag, "_z"}, 32'(flag_z), 32'(ez));
        chk({tag, "_n"}, 32'(flag_n), 32'(en));
        @(negedge clk);
        chk({tag, "_rv_after"}, 32'(res_valid), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Power-on reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv", 32'(res_valid), 32'd0);
        chk("rst_res", 32'(res_data), 32'd0);
        chk("rst_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Reset asserted mid-EXEC aborts the op
        ext_wr(3'd1, 16'h1234);
        ext_wr(3'd2, 16'h0FFF);
        dbg_chk("load_r1", 3'd1, 16'h1234);
        drive_op(3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy_exec", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(op_ready), 32'd1);
        chk("abort_rv0", 32'(res_valid), 32'd0);
        chk("abort_res", 32'(res_data), 32'd0);
        chk("abort_flags", {29'd0, flag_c, flag_z, flag_n}, 32'd0);
        @(negedge clk);
        chk("abort_rv1", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("abort_rv2", 32'(res_valid), 32'd0);
        dbg_chk("abort_r3", 3'd3, 16'h0000);
        dbg_chk("abort_r1_cleared", 3'd1, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_rel", 32'(op_ready), 32'd1);
        chk("abort_rv_rel", 32'(res_valid), 32'd0);

        // Basic add
        ext_wr(3'd1, 16'h1234);
        ext_wr(3'd2, 16'h0FFF);
        run_op("add", 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1,
               16'h2233, 1'b0, 1'b0, 1'b0);
        dbg_chk("add_r3", 3'd3, 16'h2233);

        // Back-to-back with dependency: op2 accepted in op1's WB reads the written R3
        ext_wr(3'd3, 16'h0000);
        drive_op(3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_rv1", 32'(res_valid), 32'd1);
        chk("b2b_res1", 32'(res_data), 32'h2233);
        chk("b2b_ready_wb", 32'(op_ready), 32'd1);
        drive_op(3'd5, 3'd3, 3'd0, 1'b1, 16'h0001, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        op_valid = 1'b0;
        chk("b2b_rv_gap1", 32'(res_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_rv_gap2", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("b2b_rv2", 32'(res_valid), 32'd1);
        chk("b2b_res2", 32'(res_data), 32'h2234);
        @(negedge clk);
        dbg_chk("b2b_r5", 3'd5, 16'h2234);
        dbg_chk("b2b_r3", 3'd3, 16'h2233);

        // Carry chain
        ext_wr(3'd1, 16'hFFFF);
        ext_wr(3'd2, 16'h0001);
        run_op("wrap", 3'd7, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1,
               16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("usec", 3'd4, 3'd0, 3'd0, 1'b1, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b1,
               16'h0001, 1'b0, 1'b0, 1'b0);
        dbg_chk("usec_r4", 3'd4, 16'h0001);

        // Subtraction, no borrow and borrow
        run_op("sub_nb", 3'd0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0,
               16'hFFFE, 1'b1, 1'b0, 1'b1);
        run_op("sub_b", 3'd0, 3'd2, 3'd1, 1'b0, 16'h0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0,
               16'h0002, 1'b0, 1'b0, 1'b0);
        dbg_chk("sub_r0_untouched", 3'd0, 16'h0000);

        // Host write while busy is dropped
        drive_op(3'd0, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        op_valid  = 1'b0;
        ext_we    = 1'b1;
        ext_waddr = 3'd2;
        ext_wdata = 16'hAAAA;
        @(negedge clk);
        ext_we = 1'b0;
        @(negedge clk);
        chk("arb_c_set", 32'(flag_c), 32'd1);
        @(negedge clk);
        dbg_chk("arb_r2_kept", 3'd2, 16'h0001);

        // Host write and accept in the same IDLE cycle; logic op clears carry
        ext_we    = 1'b1;
        ext_waddr = 3'd2;
        ext_wdata = 16'h5555;
        run_op("xor", 3'd6, 3'd2, 3'd0, 1'b1, 16'hFFFF, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1,
               16'hAAAA, 1'b0, 1'b0, 1'b1);
        dbg_chk("xor_r6", 3'd6, 16'hAAAA);
        dbg_chk("xor_r2", 3'd2, 16'h5555);

        // 32-bit instance
        w_ext_we    = 1'b1;
        w_ext_waddr = 3'd1;
        w_ext_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        w_ext_we = 1'b0;
        w_op_dst = 3'd2; w_op_src_a = 3'd1; w_op_b_imm = 1'b1; w_op_imm = 32'd1;
        w_op_mode = 1'b0; w_op_sel = 4'b1001; w_op_cin = 1'b0; w_op_wb = 1'b1;
        w_op_valid = 1'b1;
        @(negedge clk);
        w_op_valid = 1'b0;
        @(negedge clk);
        chk("w32_rv_exec", 32'(w_res_valid), 32'd0);
        @(negedge clk);
        chk("w32_rv", 32'(w_res_valid), 32'd1);
        chk("w32_res", w_res_data, 32'h00000000);
        chk("w32_c", 32'(w_flag_c), 32'd1);
        chk("w32_z", 32'(w_flag_z), 32'd1);
        chk("w32_n", 32'(w_flag_n), 32'd0);
        @(negedge clk);
        w_dbg_raddr = 3'd2;
        #1;
        chk("w32_r2", w_dbg_rdata, 32'h00000000);
        w_dbg_raddr = 3'd1;
        #1;
        chk("w32_r1", w_dbg_rdata, 32'hFFFFFFFF);
        chk("w32_busy", 32'(w_busy), 32'd0);
        chk("w32_ready", 32'(w_op_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_exec_core.md
# cpu_exec_core

Parametrised multi-cycle execution core that succeeds the flat regfile+ALU datapath: it sequences operand read, 74181-style ALU execution and register write-back under a valid/ready handshake. It adds a flag register (C/Z/N), carry chaining for multi-word arithmetic, a host load port and a debug read port. It sits between the instruction decoder and the register file/ALU slices. Width is generalised to any multiple of 4 bits (one 74181 slice per nibble).

## Interface
Parameters:
- DATA_WIDTH, 16, datapath width; must be a multiple of 4, minimum 4
- NUM_REGS, 8, register count; power of two, minimum 2
- ADDR_WIDTH, $clog2(NUM_REGS), register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- op_valid  in  1  operation request
- op_ready  out  1  core accepts an operation this cycle
- op_dst / op_src_a / op_src_b  in  ADDR_WIDTH each  destination and source registers
- op_b_imm  in  1  0: B from op_src_b; 1: B from op_imm
- op_imm  in  DATA_WIDTH  immediate operand
- op_mode  in  1  1: logic, 0: arithmetic
- op_sel  in  4  ALU function select (74181 active-high table)
- op_cin  in  1  carry in, active-high (1 adds one)
- op_use_carry  in  1  1: carry in taken from flag_c instead of op_cin
- op_wb  in  1  1: write result to op_dst
- ext_we  in  1  host register write strobe
- ext_waddr  in  ADDR_WIDTH  host write address
- ext_wdata  in  DATA_WIDTH  host write data
- dbg_raddr  in  ADDR_WIDTH  debug read address
- dbg_rdata  out  DATA_WIDTH  combinational register contents at dbg_raddr
- res_valid  out  1  one-cycle pulse; result on res_data
- res_data  out  DATA_WIDTH  registered ALU result
- flag_c / flag_z / flag_n  out  1  carry-out, zero, MSB of last result
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, READ, EXEC, WB. IDLE→READ on op_valid && op_ready; READ→EXEC; EXEC→WB; WB→READ if a new op is accepted, else IDLE.
- op_ready = 1 in IDLE and WB; 0 in READ and EXEC.
- Accept: all op_* fields latched into an op register at the accepting edge.
- READ: A = reg[src_a], B = op_b_imm ? imm : reg[src_b], Cin = op_use_carry ? flag_c : op_cin; all latched into operand registers.
- EXEC: ALU evaluated; result → res_data; flag_c ← carry out of MSB slice (forced 0 when op_mode=1); flag_z ← (result==0); flag_n ← result[DATA_WIDTH-1].
- WB: res_valid=1; if op_wb, reg[dst] ← res_data at end of WB.
- Arithmetic is modulo 2^DATA_WIDTH. sel=1001/mode=0 is A+B+Cin; sel=0110/mode=0 is A−B−1+Cin (C=1 means no borrow).
- ext_we is honoured only in IDLE, otherwise dropped silently. ext write and op accept in the same IDLE cycle: both take effect; READ sees the new value.
- op_wb write in WB uses the same register file port. ext_we cannot coincide with it since ext_we is ignored outside IDLE.

## Timing
- Reset (async assert, sync release) clears all registers, FSM→IDLE, res_data=0, res_valid=0, flag_c/z/n=0, busy=0, op_ready=1.
- Latency: accept edge E0 → res_valid high in the cycle after E2 (3 cycles). Write-back is visible on dbg_rdata after edge E3.
- Back-to-back throughput is one op per 3 cycles. An op accepted in WB reads its operands after the WB write, so there is no RAW hazard and no forwarding.
- Reset asserted mid-operation aborts the op: no write-back, no res_valid pulse, flags cleared.
- dbg_rdata is purely combinational from the register array.

## Test plan
- Reset: assert reset=0 mid-EXEC of an op with op_wb=1 → dst unchanged, res_valid never pulses, all outputs 0, op_ready=1 after release.
- Add: ext load R1=0x1234, R2=0x0FFF; op R3=R1+R2 (sel 1001, mode 0, cin 0, wb) → res_valid at accept+3 with res_data 0x2233, C=0, Z=0; dbg R3=0x2233.
- Carry chain: R1=0xFFFF, R2=0x0001 add → 0x0000, C=1, Z=1. Then R4 = R0(0)+imm 0 with op_use_carry → 0x0001, C=0.
- Back-to-back dependency: op1 R3=R1+R2; op2 R5=R3+imm 1 accepted in op1's WB cycle → R5=0x2234, res_valid pulses 3 cycles apart.
- Port arbitration: ext_we to R2=0xAAAA while busy → ignored, R2 unchanged. ext_we in IDLE in the same cycle as accepting R6=R2 XOR imm 0xFFFF (mode 1) → uses the new R2 value; flag_c=0.
- Width: DATA_WIDTH=32 instance computes 0xFFFFFFFF + imm 1 → 0x00000000, C=1, Z=1, N=0.
